fp_swap_align_stage: RTL
========================

// Module: fp_swap_align_stage
// PURPOSE
//  Parametrised, pipelined operand-order stage for the vecunit FP adder: per lane, compares |A| vs |B|,
//  swaps so the larger-magnitude operand exits on port A, and produces effective sign, effective-subtract
//  flag and saturated exponent difference for the alignment shifter. Sits between operand unpack and align;
//  one register stage with valid/ready handshake, LANES independent lanes sharing one handshake.
// PARAMETERS
//  LANES   4   number of parallel lanes
//  EXP_W   8   exponent width (biased)
//  MAN_W   23  mantissa width (without hidden bit)
//  SH_W    5   exp-diff output width; diff saturates at 2**SH_W-1
// PORTS
//  clk_i        in   1                clock, rising edge
//  rst_i        in   1                async reset, active-high
//  flush_i      in   1                sync clear of all valid state
//  in_valid_i   in   1                input beat valid
//  in_ready_o   out  1                stage accepts beat
//  lane_en_i    in   LANES            per-lane enable mask
//  sub_i        in   1                0=A+B, 1=A-B (all lanes)
//  a_s_i/b_s_i  in   LANES            operand signs
//  a_e_i/b_e_i  in   LANES*EXP_W      operand exponents
//  a_m_i/b_m_i  in   LANES*MAN_W      operand mantissas
//  out_valid_o  out  1                output beat valid
//  out_ready_i  in   1                downstream accepts
//  big_e_o/small_e_o  out LANES*EXP_W  exponents after swap
//  big_m_o/small_m_o  out LANES*MAN_W  mantissas after swap
//  res_s_o      out  LANES            result sign
//  eff_sub_o    out  LANES            effective subtraction
//  ediff_o      out  LANES*SH_W       big_e - small_e, saturated
//  swap_o       out  LANES            1 = operands were swapped
//  lane_en_o    out  LANES            registered lane mask
// BEHAVIOUR
//  - Reset (rst_i=1, async): out_valid_o=0, every data output 0; in_ready_o=1 once reset deasserts.
//  - Transfer on in_valid_i&in_ready_o; output presented next cycle (latency 1); held stable while
//    out_valid_o&!out_ready_i. Data regs load only on transfer.
//  - Per lane: bs = b_s ^ sub_i; swap = {b_e,b_m} > {a_e,a_m} (unsigned concat compare); tie -> swap=0.
//  - big = swap?B:A, small = swap?A:B; res_s = swap ? bs : a_s; eff_sub = a_s ^ bs.
//  - ediff = big_e - small_e (never negative); if > 2**SH_W-1 output 2**SH_W-1.
//  - Exact cancel (|A|==|B|, eff_sub=1): res_s = a_s; rounding-mode sign fixup is downstream's job.
//  - Lane with lane_en_i=0: all its data outputs registered as 0, lane_en_o bit 0.
//  - flush_i: next edge out_valid_o=0 (and skid empty); a beat offered same cycle is dropped; flush wins
//    over simultaneous transfer. Reset mid-beat discards it, no partial output.
// CONFIGURATION
//  SWAP_SKID_EN defined: 2-entry skid buffer; in_ready_o is a flop (=skid empty), no comb path
//    out_ready_i->in_ready_o; full throughput; skid data output first, order preserved.
//  Undefined: in_ready_o = !out_valid_o | out_ready_i (combinational), single output register.
//  Functional results identical in both; only ready timing differs.
// STRUCTURE
//  Shared vecunit FP package: EXP_W/MAN_W defaults, lane operand struct typedef (s,e,m), ediff_sat
//  function. One sub-module fp_swap_lane (combinational compare/swap/sign/ediff per lane), generated LANES
//  times; this module holds handshake, pipeline and optional skid registers.
// TESTING (LANES=4, EXP_W=8, MAN_W=23, SH_W=5)
//  1 A=(0,0x80,0x0), B=(0,0x82,0x0), sub=0 -> swap=1, big_e=0x82, ediff=2, res_s=0, eff_sub=0, 1 cycle later.
//  2 A=(1,0x90,0x100), B=(0,0x90,0x100), sub=1 -> tie swap=0, eff_sub=0, res_s=1; A-B with b_s=1 -> eff_sub=1.
//  3 A.e=0xFE, B.e=0x01 -> ediff=31 (saturated); B.e=0xFE, A.e=0x01 -> swap=1, ediff=31.
//  4 out_ready_i=0 for 5 cycles with in_valid_i=1 -> output stable, no beat lost/duplicated; random
//    back-pressure over 1000 beats -> scoreboard match, both macro settings.
//  5 lane_en_i=4'b0101 -> lanes 1,3 outputs 0, lane_en_o=4'b0101; flush_i with out_valid_o=1 -> 0 next cycle.
//  6 rst_i pulsed mid-stall -> out_valid_o=0 immediately (async), outputs 0, next beat accepted cleanly.

Source files
------------

// File: rtl/fp_swap_align_stage_pkg.sv
// Shared vecunit FP definitions: default field widths, lane operand type and
// the exponent-difference saturation helper used by the swap/align stage.
package fp_swap_align_stage_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_SH_W  = 5;

  typedef struct packed {
    logic                s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } lane_op_t;

  // Clamp an exponent difference to what the alignment shifter can encode.
  function automatic logic [31:0] ediff_sat(input logic [31:0] diff, input int unsigned sh_w);
    logic [31:0] lim;
    lim = (32'd1 << sh_w) - 32'd1;
    return (diff > lim) ? lim : diff;
  endfunction

endpackage

// File: rtl/fp_swap_lane.sv
// Per-lane combinational magnitude compare, operand swap, sign and exponent
// difference; a disabled lane drives all of its results to zero.
module fp_swap_lane
  import fp_swap_align_stage_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int SH_W  = FP_SH_W
) (
  input  logic             en_i,
  input  logic             sub_i,
  input  logic             a_s_i,
  input  logic [EXP_W-1:0] a_e_i,
  input  logic [MAN_W-1:0] a_m_i,
  input  logic             b_s_i,
  input  logic [EXP_W-1:0] b_e_i,
  input  logic [MAN_W-1:0] b_m_i,
  output logic [EXP_W-1:0] big_e_o,
  output logic [EXP_W-1:0] small_e_o,
  output logic [MAN_W-1:0] big_m_o,
  output logic [MAN_W-1:0] small_m_o,
  output logic [SH_W-1:0]  ediff_o,
  output logic             res_s_o,
  output logic             eff_sub_o,
  output logic             swap_o
);

  logic             w_bs;
  logic             w_swap;
  logic [EXP_W-1:0] w_big_e;
  logic [EXP_W-1:0] w_small_e;
  logic [EXP_W-1:0] w_diff;

  // Equal magnitudes keep A in front, so an exact cancel takes A's sign.
  assign w_bs      = b_s_i ^ sub_i;
  assign w_swap    = {b_e_i, b_m_i} > {a_e_i, a_m_i};
  assign w_big_e   = w_swap ? b_e_i : a_e_i;
  assign w_small_e = w_swap ? a_e_i : b_e_i;
  assign w_diff    = w_big_e - w_small_e;

  assign big_e_o   = en_i ? w_big_e : '0;
  assign small_e_o = en_i ? w_small_e : '0;
  assign big_m_o   = en_i ? (w_swap ? b_m_i : a_m_i) : '0;
  assign small_m_o = en_i ? (w_swap ? a_m_i : b_m_i) : '0;
  assign ediff_o   = en_i ? SH_W'(ediff_sat(32'(w_diff), SH_W)) : '0;
  assign res_s_o   = en_i & (w_swap ? w_bs : a_s_i);
  assign eff_sub_o = en_i & (a_s_i ^ w_bs);
  assign swap_o    = en_i & w_swap;

endmodule

// File: rtl/fp_swap_align_stage.sv
// Operand-order pipeline stage for the vecunit FP adder: LANES swap lanes behind one
// valid/ready register stage. Define SWAP_SKID_EN for a registered-ready 2-entry skid.
module fp_swap_align_stage
  import fp_swap_align_stage_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int SH_W  = FP_SH_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES-1:0]       lane_en_i,
  input  logic                   sub_i,
  input  logic [LANES-1:0]       a_s_i,
  input  logic [LANES-1:0]       b_s_i,
  input  logic [LANES*EXP_W-1:0] a_e_i,
  input  logic [LANES*EXP_W-1:0] b_e_i,
  input  logic [LANES*MAN_W-1:0] a_m_i,
  input  logic [LANES*MAN_W-1:0] b_m_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*EXP_W-1:0] big_e_o,
  output logic [LANES*EXP_W-1:0] small_e_o,
  output logic [LANES*MAN_W-1:0] big_m_o,
  output logic [LANES*MAN_W-1:0] small_m_o,
  output logic [LANES-1:0]       res_s_o,
  output logic [LANES-1:0]       eff_sub_o,
  output logic [LANES*SH_W-1:0]  ediff_o,
  output logic [LANES-1:0]       swap_o,
  output logic [LANES-1:0]       lane_en_o
);

  // Each lane's results travel as one packed record inside the beat word.
  localparam int BE_O = 0;
  localparam int SE_O = EXP_W;
  localparam int BM_O = 2*EXP_W;
  localparam int SM_O = 2*EXP_W + MAN_W;
  localparam int ED_O = 2*EXP_W + 2*MAN_W;
  localparam int ES_O = ED_O + SH_W;
  localparam int RS_O = ES_O + 1;
  localparam int SW_O = RS_O + 1;
  localparam int EN_O = SW_O + 1;
  localparam int LW   = EN_O + 1;

  logic [LANES*LW-1:0] w_beat;
  logic [LANES*LW-1:0] r_out_data;
  logic                r_out_valid;
  logic                w_in_fire;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    fp_swap_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SH_W(SH_W)) u_lane (
      .en_i      (lane_en_i[gi]),
      .sub_i     (sub_i),
      .a_s_i     (a_s_i[gi]),
      .a_e_i     (a_e_i[gi*EXP_W +: EXP_W]),
      .a_m_i     (a_m_i[gi*MAN_W +: MAN_W]),
      .b_s_i     (b_s_i[gi]),
      .b_e_i     (b_e_i[gi*EXP_W +: EXP_W]),
      .b_m_i     (b_m_i[gi*MAN_W +: MAN_W]),
      .big_e_o   (w_beat[gi*LW+BE_O +: EXP_W]),
      .small_e_o (w_beat[gi*LW+SE_O +: EXP_W]),
      .big_m_o   (w_beat[gi*LW+BM_O +: MAN_W]),
      .small_m_o (w_beat[gi*LW+SM_O +: MAN_W]),
      .ediff_o   (w_beat[gi*LW+ED_O +: SH_W]),
      .res_s_o   (w_beat[gi*LW+RS_O]),
      .eff_sub_o (w_beat[gi*LW+ES_O]),
      .swap_o    (w_beat[gi*LW+SW_O])
    );
    assign w_beat[gi*LW+EN_O] = lane_en_i[gi];

    assign big_e_o[gi*EXP_W +: EXP_W]   = r_out_data[gi*LW+BE_O +: EXP_W];
    assign small_e_o[gi*EXP_W +: EXP_W] = r_out_data[gi*LW+SE_O +: EXP_W];
    assign big_m_o[gi*MAN_W +: MAN_W]   = r_out_data[gi*LW+BM_O +: MAN_W];
    assign small_m_o[gi*MAN_W +: MAN_W] = r_out_data[gi*LW+SM_O +: MAN_W];
    assign ediff_o[gi*SH_W +: SH_W]     = r_out_data[gi*LW+ED_O +: SH_W];
    assign eff_sub_o[gi]                = r_out_data[gi*LW+ES_O];
    assign res_s_o[gi]                  = r_out_data[gi*LW+RS_O];
    assign swap_o[gi]                   = r_out_data[gi*LW+SW_O];
    assign lane_en_o[gi]                = r_out_data[gi*LW+EN_O];
  end

  assign out_valid_o = r_out_valid;

`ifdef SWAP_SKID_EN
  logic                r_skid_valid;
  logic [LANES*LW-1:0] r_skid_data;
  logic                w_out_free;

  // Ready depends only on the skid flop; the skid is drained first to keep order.
  assign in_ready_o = ~r_skid_valid;
  assign w_in_fire  = in_valid_i & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_beat;
    end
  end
`else
  assign in_ready_o = ~r_out_valid | out_ready_i;
  assign w_in_fire  = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule
